wb_burst_master: RTL and testbench

- Wishbone initiator that drives the WB slave port of the SDRAM controller top (wb2sdrc side) from a simple command/stream interface.
- Each accepted command becomes one WB cycle of 1..2^bl-1 beats, using incrementing-burst CTI tagging.
- Write data comes in as a valid/ready stream; read data goes out as a valid pulse stream.
- Used by DMA and test-traffic engines that share the controller.

---
 rtl/wb_burst_master_pkg.sv | 16 +
 rtl/wb_burst_wr_hold.sv | 51 +++++
 rtl/wb_burst_master.sv | 211 +++++++++++++++++++++
 tb/tb_wb_burst_master.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_burst_master_pkg.sv
// Shared constants and state encoding for the Wishbone burst master.
package wb_burst_master_pkg;

  // Wishbone cycle-type identifiers
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWr   = 2'd1,
    StRd   = 2'd2,
    StFin  = 2'd3
  } state_e;

endpackage

// File: rtl/wb_burst_wr_hold.sv
// One-word write holding register between the write stream and the WB bus.
module wb_burst_wr_hold #(
  parameter int unsigned DW = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_clr,    // discard any held word
  input  logic            i_more,   // more words still to be fetched for this command
  input  logic            i_ack,    // qualified WB ack of the held word
  input  logic [DW-1:0]   i_dat,
  input  logic [DW/8-1:0] i_sel,
  input  logic            i_valid,
  output logic            o_ready,
  output logic            o_valid,
  output logic [DW-1:0]   o_dat,
  output logic [DW/8-1:0] o_sel
);

  logic            r_valid;
  logic [DW-1:0]   r_dat;
  logic [DW/8-1:0] r_sel;
  logic            w_load;

  // Accept a new word when empty or when the held word is leaving this cycle.
  always_comb begin
    o_ready = i_more && (!r_valid || i_ack);
    w_load  = i_valid && o_ready;
  end

  // Holding register: a load wins over the ack that frees the slot in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_dat   <= '0;
      r_sel   <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_dat   <= i_dat;
      r_sel   <= i_sel;
    end else if (i_ack) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_dat   = r_dat;
  assign o_sel   = r_sel;

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone burst initiator: one command becomes one incrementing-burst WB cycle.
module wb_burst_master
  import wb_burst_master_pkg::*;
#(
  parameter int unsigned dw     = 32,
  parameter int unsigned aw     = 25,
  parameter int unsigned bl     = 9,
  parameter int unsigned TO_CYC = 1023
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_req,
  output logic            cmd_ack,
  input  logic [aw-1:0]   cmd_addr,
  input  logic [bl-1:0]   cmd_len,
  input  logic            cmd_wr,
  input  logic [dw-1:0]   wdat,
  input  logic [dw/8-1:0] wdat_sel,
  input  logic            wdat_valid,
  output logic            wdat_ready,
  output logic [dw-1:0]   rdat,
  output logic            rdat_valid,
  output logic            rdat_last,
  output logic            done,
  output logic            done_err,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [aw-1:0]   wb_addr_o,
  output logic [dw-1:0]   wb_dat_o,
  output logic [dw/8-1:0] wb_sel_o,
  output logic [2:0]      wb_cti_o,
  input  logic [dw-1:0]   wb_dat_i,
  input  logic            wb_ack_i
);

  // Watchdog only needs to count up to TO_CYC-1; the abort fires on the step to TO_CYC.
  localparam int unsigned WdW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

  state_e            r_state, w_state_d;
  logic [aw-1:0]     r_addr;
  logic [bl-1:0]     r_len;
  logic [bl-1:0]     r_acked;
  logic [bl-1:0]     r_fetched;
  logic              r_err;
  logic [WdW-1:0]    r_wd;
  logic [dw-1:0]     r_rdat;
  logic              r_rdat_valid;
  logic              r_rdat_last;

  logic              w_stb;
  logic              w_ack;
  logic              w_last;
  logic              w_timeout;
  logic              w_accept;
  logic              w_more;
  logic              w_hold_clr;
  logic              w_hold_valid;
  logic [dw-1:0]     w_hold_dat;
  logic [dw/8-1:0]   w_hold_sel;

  // Bus qualifiers shared by the FSM, counters and the holding register.
  always_comb begin
    w_stb      = ((r_state == StWr) && w_hold_valid) || (r_state == StRd);
    w_ack      = wb_ack_i && w_stb;
    w_last     = (r_acked == (r_len - 1'b1));
    w_timeout  = (TO_CYC != 0) && w_stb && !wb_ack_i && (r_wd == WdW'(TO_CYC - 1));
    w_accept   = (r_state == StIdle) && cmd_req;
    w_more     = (r_state == StWr) && (r_fetched < r_len);
    w_hold_clr = (r_state != StWr) || w_timeout;
  end

  wb_burst_wr_hold #(
    .DW (dw)
  ) u_wr_hold (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_clr   (w_hold_clr),
    .i_more  (w_more),
    .i_ack   (w_ack),
    .i_dat   (wdat),
    .i_sel   (wdat_sel),
    .i_valid (wdat_valid),
    .o_ready (wdat_ready),
    .o_valid (w_hold_valid),
    .o_dat   (w_hold_dat),
    .o_sel   (w_hold_sel)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM next state and control outputs.
  always_comb begin
    w_state_d = r_state;
    cmd_ack   = 1'b0;
    done      = 1'b0;
    done_err  = 1'b0;
    wb_cyc_o  = 1'b0;
    wb_stb_o  = 1'b0;
    wb_we_o   = 1'b0;
    wb_cti_o  = CTI_CLASSIC;
    unique case (r_state)
      StIdle: begin
        cmd_ack = cmd_req;
        if (cmd_req) begin
          if (cmd_len == '0) begin
            w_state_d = StFin;
          end else begin
            w_state_d = cmd_wr ? StWr : StRd;
          end
        end
      end
      StWr, StRd: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = w_stb;
        wb_we_o  = (r_state == StWr);
        wb_cti_o = w_last ? CTI_EOB : CTI_INCR;
        if (w_timeout || (w_ack && w_last)) begin
          w_state_d = StFin;
        end
      end
      StFin: begin
        done      = 1'b1;
        done_err  = r_err;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Command latch plus beat/fetch counters; everything restarts on command accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr    <= '0;
      r_len     <= '0;
      r_acked   <= '0;
      r_fetched <= '0;
      r_err     <= 1'b0;
    end else if (w_accept) begin
      r_addr    <= cmd_addr;
      r_len     <= cmd_len;
      r_acked   <= '0;
      r_fetched <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_ack) begin
        r_acked <= r_acked + 1'b1;
      end
      if (wdat_valid && wdat_ready) begin
        r_fetched <= r_fetched + 1'b1;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  // Watchdog: counts consecutive strobe cycles without an ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wd <= '0;
    end else if (w_stb && !wb_ack_i && !w_timeout) begin
      r_wd <= r_wd + 1'b1;
    end else begin
      r_wd <= '0;
    end
  end

  // Read return: register each acked read beat into a one-cycle pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdat       <= '0;
      r_rdat_valid <= 1'b0;
      r_rdat_last  <= 1'b0;
    end else if ((r_state == StRd) && w_ack) begin
      r_rdat       <= wb_dat_i;
      r_rdat_valid <= 1'b1;
      r_rdat_last  <= w_last;
    end else begin
      r_rdat_valid <= 1'b0;
      r_rdat_last  <= 1'b0;
    end
  end

  // Datapath outputs; address wraps modulo 2^aw.
  always_comb begin
    wb_addr_o = '0;
    wb_dat_o  = '0;
    wb_sel_o  = '0;
    if (r_state == StWr) begin
      wb_addr_o = r_addr + aw'(r_acked);
      wb_dat_o  = w_hold_dat;
      wb_sel_o  = w_hold_sel;
    end else if (r_state == StRd) begin
      wb_addr_o = r_addr + aw'(r_acked);
      wb_sel_o  = {(dw/8){1'b1}};
    end
  end

  assign rdat       = r_rdat;
  assign rdat_valid = r_rdat_valid;
  assign rdat_last  = r_rdat_last;

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed self-checking bench for wb_burst_master (watchdog set to 8 cycles).
module tb_wb_burst_master;

  localparam int DW = 32;
  localparam int AW = 25;
  localparam int BL = 9;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            cmd_req = 1'b0;
  logic            cmd_ack;
  logic [AW-1:0]   cmd_addr = '0;
  logic [BL-1:0]   cmd_len = '0;
  logic            cmd_wr = 1'b0;
  logic [DW-1:0]   wdat = '0;
  logic [DW/8-1:0] wdat_sel = '0;
  logic            wdat_valid = 1'b0;
  logic            wdat_ready;
  logic [DW-1:0]   rdat;
  logic            rdat_valid;
  logic            rdat_last;
  logic            done;
  logic            done_err;
  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic            wb_we_o;
  logic [AW-1:0]   wb_addr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [2:0]      wb_cti_o;
  logic [DW-1:0]   wb_dat_i = '0;
  logic            wb_ack_i = 1'b0;

  wb_burst_master #(
    .dw     (DW),
    .aw     (AW),
    .bl     (BL),
    .TO_CYC (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_req    (cmd_req),
    .cmd_ack    (cmd_ack),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_wr     (cmd_wr),
    .wdat       (wdat),
    .wdat_sel   (wdat_sel),
    .wdat_valid (wdat_valid),
    .wdat_ready (wdat_ready),
    .rdat       (rdat),
    .rdat_valid (rdat_valid),
    .rdat_last  (rdat_last),
    .done       (done),
    .done_err   (done_err),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_addr_o  (wb_addr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_sel_o   (wb_sel_o),
    .wb_cti_o   (wb_cti_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Per-command log, filled by run()
  logic [AW-1:0] l_addr [16];
  logic [2:0]    l_cti  [16];
  logic [31:0]   l_dat  [16];
  logic [3:0]    l_sel  [16];
  logic          l_we   [16];
  logic [31:0]   l_rdat [16];
  logic          l_rlast[16];
  int n_ack, n_fetch, n_ready, n_rd, n_stb, n_gap, n_cyc, n_cmdack;
  int ack_cyc_last, done_cyc;
  logic got_done, got_err;

  logic [31:0] rd_tab [16];
  logic [3:0]  sel_tab[4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and act as an always-ready (or never-ready) slave until done.
  task automatic run(input logic wr, input logic [AW-1:0] addr, input logic [BL-1:0] len,
                     input logic [31:0] wbase, input int gap_after, input int gap_len,
                     input bit ack_en);
    int  gap_left;
    bit  req;
    gap_left = gap_len;
    req = 1'b1;
    n_ack = 0; n_fetch = 0; n_ready = 0; n_rd = 0; n_stb = 0; n_gap = 0; n_cyc = 0;
    n_cmdack = 0; ack_cyc_last = -1; done_cyc = -1; got_done = 1'b0; got_err = 1'b0;
    for (int cyc = 0; cyc < 80 && !got_done; cyc++) begin
      cmd_req    = req;
      cmd_addr   = addr;
      cmd_len    = len;
      cmd_wr     = wr;
      wdat       = wbase + 32'(n_fetch);
      wdat_sel   = sel_tab[n_fetch % 4];
      wdat_valid = 1'b1;
      if (n_fetch == gap_after && gap_left > 0) begin
        wdat_valid = 1'b0;
        gap_left--;
      end
      wb_ack_i = ack_en && wb_stb_o;
      wb_dat_i = rd_tab[n_ack % 16];
      #1;
      if (cmd_ack) begin
        n_cmdack++;
        req = 1'b0;
      end
      if (wdat_ready) n_ready++;
      if (wdat_ready && wdat_valid) n_fetch++;
      if (wb_cyc_o) n_cyc++;
      if (wb_stb_o) n_stb++;
      if (wb_cyc_o && !wb_stb_o) n_gap++;
      if (wb_ack_i && wb_stb_o && n_ack < 16) begin
        l_addr[n_ack] = wb_addr_o;
        l_cti[n_ack]  = wb_cti_o;
        l_dat[n_ack]  = wb_dat_o;
        l_sel[n_ack]  = wb_sel_o;
        l_we[n_ack]   = wb_we_o;
        n_ack++;
        ack_cyc_last = cyc;
      end
      if (rdat_valid && n_rd < 16) begin
        l_rdat[n_rd]  = rdat;
        l_rlast[n_rd] = rdat_last;
        n_rd++;
      end
      if (done) begin
        got_done = 1'b1;
        got_err  = done_err;
        done_cyc = cyc;
      end
      @(posedge clk);
      #1;
    end
    cmd_req    = 1'b0;
    wdat_valid = 1'b0;
    wb_ack_i   = 1'b0;
    chk("done_seen", 64'(got_done), 64'd1);
  endtask

  initial begin
    sel_tab[0] = 4'hF; sel_tab[1] = 4'h3; sel_tab[2] = 4'hC; sel_tab[3] = 4'h5;
    for (int i = 0; i < 16; i++) rd_tab[i] = 32'hDEAD_0000 + 32'(i);

    // Reset state
    #12;
    chk("rst_cyc", 64'(wb_cyc_o), 64'd0);
    chk("rst_stb", 64'(wb_stb_o), 64'd0);
    chk("rst_cti", 64'(wb_cti_o), 64'd0);
    chk("rst_addr", 64'(wb_addr_o), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rvalid", 64'(rdat_valid), 64'd0);
    chk("rst_wready", 64'(wdat_ready), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: write 0x100 len 4, data A0..A3
    run(1'b1, 25'h100, 9'd4, 32'hA0, -1, 0, 1'b1);
    chk("t1_cmdack", 64'(n_cmdack), 64'd1);
    chk("t1_nack", 64'(n_ack), 64'd4);
    chk("t1_nready", 64'(n_ready), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_addr%0d", i), 64'(l_addr[i]), 64'h100 + 64'(i));
      chk($sformatf("t1_dat%0d", i), 64'(l_dat[i]), 64'hA0 + 64'(i));
      chk($sformatf("t1_sel%0d", i), 64'(l_sel[i]), 64'(sel_tab[i]));
      chk($sformatf("t1_we%0d", i), 64'(l_we[i]), 64'd1);
      chk($sformatf("t1_cti%0d", i), 64'(l_cti[i]), (i == 3) ? 64'h7 : 64'h2);
    end
    chk("t1_err", 64'(got_err), 64'd0);
    // done is visible in the cycle right after the final ack cycle
    chk("t1_done_lat", 64'(done_cyc - ack_cyc_last), 64'd1);

    // 2: read 0x200 len 3
    rd_tab[0] = 32'h11; rd_tab[1] = 32'h22; rd_tab[2] = 32'h33;
    run(1'b0, 25'h200, 9'd3, 32'h0, -1, 0, 1'b1);
    chk("t2_nrd", 64'(n_rd), 64'd3);
    chk("t2_rdat0", 64'(l_rdat[0]), 64'h11);
    chk("t2_rdat1", 64'(l_rdat[1]), 64'h22);
    chk("t2_rdat2", 64'(l_rdat[2]), 64'h33);
    chk("t2_last0", 64'(l_rlast[0]), 64'd0);
    chk("t2_last1", 64'(l_rlast[1]), 64'd0);
    chk("t2_last2", 64'(l_rlast[2]), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t2_sel%0d", i), 64'(l_sel[i]), 64'hF);
      chk($sformatf("t2_we%0d", i), 64'(l_we[i]), 64'd0);
      chk($sformatf("t2_addr%0d", i), 64'(l_addr[i]), 64'h200 + 64'(i));
    end

    // 3: single-beat write, then zero-length command
    run(1'b1, 25'h40, 9'd1, 32'h55, -1, 0, 1'b1);
    chk("t3a_nack", 64'(n_ack), 64'd1);
    chk("t3a_cti", 64'(l_cti[0]), 64'h7);
    chk("t3a_dat", 64'(l_dat[0]), 64'h55);
    run(1'b1, 25'h80, 9'd0, 32'h0, -1, 0, 1'b1);
    chk("t3b_cmdack", 64'(n_cmdack), 64'd1);
    chk("t3b_ncyc", 64'(n_cyc), 64'd0);
    chk("t3b_err", 64'(got_err), 64'd0);

    // 4: write len 4 with a 5-cycle stream gap after the second word
    run(1'b1, 25'h300, 9'd4, 32'hB0, 2, 5, 1'b1);
    chk("t4_nack", 64'(n_ack), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_dat%0d", i), 64'(l_dat[i]), 64'hB0 + 64'(i));
      chk($sformatf("t4_addr%0d", i), 64'(l_addr[i]), 64'h300 + 64'(i));
    end
    chk("t4_ncyc", 64'(n_cyc), 64'd10);
    chk("t4_ngap", 64'(n_gap), 64'd6);

    // 5: watchdog abort on a read that never gets acked, then a normal read
    run(1'b0, 25'h300, 9'd2, 32'h0, -1, 0, 1'b0);
    chk("t5_nstb", 64'(n_stb), 64'd8);
    chk("t5_err", 64'(got_err), 64'd1);
    chk("t5_nrd", 64'(n_rd), 64'd0);
    rd_tab[0] = 32'hCAFE_0001; rd_tab[1] = 32'hCAFE_0002;
    run(1'b0, 25'h310, 9'd2, 32'h0, -1, 0, 1'b1);
    chk("t5b_err", 64'(got_err), 64'd0);
    chk("t5b_nrd", 64'(n_rd), 64'd2);
    chk("t5b_rdat1", 64'(l_rdat[1]), 64'hCAFE_0002);

    // 6a: address wrap
    run(1'b0, 25'h1FFFFFE, 9'd3, 32'h0, -1, 0, 1'b1);
    chk("t6_addr0", 64'(l_addr[0]), 64'h1FFFFFE);
    chk("t6_addr1", 64'(l_addr[1]), 64'h1FFFFFF);
    chk("t6_addr2", 64'(l_addr[2]), 64'h0);

    // 6b: asynchronous reset mid-burst
    cmd_req  = 1'b1;
    cmd_addr = 25'h40;
    cmd_len  = 9'd5;
    cmd_wr   = 1'b0;
    wb_ack_i = 1'b0;
    #1;
    chk("t6r_cmdack", 64'(cmd_ack), 64'd1);
    @(posedge clk);
    #1;
    cmd_req = 1'b0;
    @(posedge clk);
    #1;
    chk("t6r_cyc_pre", 64'(wb_cyc_o), 64'd1);
    chk("t6r_stb_pre", 64'(wb_stb_o), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6r_cyc_now", 64'(wb_cyc_o), 64'd0);
    chk("t6r_stb_now", 64'(wb_stb_o), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t6r_nodone%0d", i), 64'(done), 64'd0);
      chk($sformatf("t6r_idle%0d", i), 64'(wb_cyc_o), 64'd0);
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
